// File: rtl/contador_m_ud.sv
// Mod-M up/down counter with clamped load, optional saturation, cascade enable and wrap-event count.
// Q, volta and voltas update one edge after their inputs; fim/meio/rco are combinational on Q and controls.
module contador_m_ud #(
  parameter int M      = 100,
  parameter int N      = 7,
  parameter int SATURA = 0,
  parameter int NV     = 8
) (
  input  logic          clock,
  input  logic          zera_as,
  input  logic          zera_s,
  input  logic          carrega,
  input  logic [N-1:0]  D,
  input  logic          conta,
  input  logic          sobe,
  output logic [N-1:0]  Q,
  output logic          fim,
  output logic          meio,
  output logic          rco,
  output logic          volta,
  output logic [NV-1:0] voltas
);

  localparam logic [N-1:0] Q_MAX   = N'(M - 1);
  localparam logic [N-1:0] Q_MEIO  = N'(M / 2);
  localparam bit           WRAP_EN = (SATURA == 0);

  logic [N-1:0] q_nxt;
  logic         wrap;

  always_comb begin
    q_nxt = Q;
    wrap  = 1'b0;
    if (zera_s) begin
      q_nxt = '0;
    end else if (carrega) begin
      q_nxt = (D > Q_MAX) ? Q_MAX : D;
    end else if (conta) begin
      if (sobe) begin
        // >= keeps Q inside 0..M-1 even if it were somehow out of range
        if (Q < Q_MAX) begin
          q_nxt = Q + N'(1);
        end else if (WRAP_EN) begin
          q_nxt = '0;
          wrap  = 1'b1;
        end else begin
          q_nxt = Q_MAX;
        end
      end else begin
        if (Q != '0) begin
          q_nxt = (Q > Q_MAX) ? Q_MAX : Q - N'(1);
        end else if (WRAP_EN) begin
          q_nxt = Q_MAX;
          wrap  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      Q      <= '0;
      volta  <= 1'b0;
      voltas <= '0;
    end else begin
      Q     <= q_nxt;
      volta <= wrap;
      if (zera_s) begin
        voltas <= '0;
      end else if (wrap) begin
        voltas <= voltas + NV'(1);
      end
    end
  end

  assign fim  = sobe ? (Q == Q_MAX) : (Q == '0);
  assign meio = (Q == Q_MEIO);
  // Masked on clear/load so a downstream stage only advances when this one actually counts.
  assign rco  = conta & fim & ~zera_s & ~carrega;

endmodule

// File: tb/tb_contador_m_ud.sv
// Bench for contador_m_ud: wrapping and saturating instances driven in parallel
// against an arithmetic reference model, with directed scenarios followed by random stimulus.
module tb_contador_m_ud;

  localparam int M  = 100;
  localparam int N  = 7;
  localparam int NV = 8;

  logic          clock;
  logic          zera_as, zera_s, carrega, conta, sobe;
  logic [N-1:0]  D;

  logic [N-1:0]  q0, q1;
  logic          fim0, fim1, meio0, meio1, rco0, rco1, volta0, volta1;
  logic [NV-1:0] voltas0, voltas1;

  contador_m_ud #(.M(M), .N(N), .SATURA(0), .NV(NV)) u_wrap (
    .clock(clock), .zera_as(zera_as), .zera_s(zera_s), .carrega(carrega), .D(D),
    .conta(conta), .sobe(sobe), .Q(q0), .fim(fim0), .meio(meio0), .rco(rco0),
    .volta(volta0), .voltas(voltas0)
  );

  contador_m_ud #(.M(M), .N(N), .SATURA(1), .NV(NV)) u_sat (
    .clock(clock), .zera_as(zera_as), .zera_s(zera_s), .carrega(carrega), .D(D),
    .conta(conta), .sobe(sobe), .Q(q1), .fim(fim1), .meio(meio1), .rco(rco1),
    .volta(volta1), .voltas(voltas1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per instance: index 0 wraps, index 1 saturates.
  int mq[2];
  int mv[2];
  int mvol[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mv[i] = 0; mvol[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit sat;
      sat = (i == 1);
      mvol[i] = 0;
      if (zera_s) begin
        mq[i] = 0; mv[i] = 0;
      end else if (carrega) begin
        mq[i] = (int'(D) < M) ? int'(D) : M - 1;
      end else if (conta) begin
        if (sobe) begin
          if (mq[i] < M - 1) mq[i] = mq[i] + 1;
          else if (!sat) begin
            mq[i] = 0; mvol[i] = 1; mv[i] = (mv[i] + 1) % (1 << NV);
          end
        end else begin
          if (mq[i] > 0) mq[i] = mq[i] - 1;
          else if (!sat) begin
            mq[i] = M - 1; mvol[i] = 1; mv[i] = (mv[i] + 1) % (1 << NV);
          end
        end
      end
    end
  endtask

  task automatic check_comb();
    for (int i = 0; i < 2; i++) begin
      logic efim;
      efim = sobe ? (mq[i] == M - 1) : (mq[i] == 0);
      chk($sformatf("fim%0d", i),  (i == 0) ? fim0 : fim1, efim);
      chk($sformatf("meio%0d", i), (i == 0) ? meio0 : meio1, mq[i] == M / 2);
      chk($sformatf("rco%0d", i),  (i == 0) ? rco0 : rco1,
          conta & efim & ~zera_s & ~carrega);
    end
  endtask

  task automatic check_regs();
    chk("q0", q0, mq[0]);
    chk("q1", q1, mq[1]);
    chk("volta0", volta0, mvol[0]);
    chk("volta1", volta1, mvol[1]);
    chk("voltas0", voltas0, mv[0]);
    chk("voltas1", voltas1, mv[1]);
  endtask

  // One clock: drive, check combinational outputs, take the edge, check registers.
  task automatic cyc(input logic zs, input logic ld, input logic [N-1:0] d,
                     input logic en, input logic up);
    zera_s = zs; carrega = ld; D = d; conta = en; sobe = up;
    #1;
    check_comb();
    @(posedge clock);
    if (!zera_as) model_step();
    #1;
    check_regs();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear before the next edge.
  task automatic areset_mid();
    #2;
    zera_as = 1'b1;
    #1;
    model_reset();
    chk("async_q0", q0, 0);
    chk("async_q1", q1, 0);
    chk("async_voltas0", voltas0, 0);
    chk("async_volta0", volta0, 0);
    @(posedge clock);
    #1;
    zera_as = 1'b0;
    check_regs();
  endtask

  initial begin
    zera_as = 1'b1; zera_s = 1'b0; carrega = 1'b0; conta = 1'b0; sobe = 1'b0; D = '0;
    model_reset();
    #7;
    check_regs();
    zera_as = 1'b0;

    // Idle after reset
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0);
    sobe = 1'b0; #1;
    chk("t1_fim_down", fim0, 1);
    sobe = 1'b1; #1;
    chk("t1_fim_up", fim0, 0);

    // Count up 20, then on to 60 passing the midpoint
    cyc(1, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 1, 1);
    chk("t2_q20", q0, 20);
    for (int k = 0; k < 40; k++) cyc(0, 0, 0, 1, 1);

    // Full period up: wrap vs saturate
    cyc(1, 0, 0, 0, 1);
    for (int k = 0; k < 100; k++) cyc(0, 0, 0, 1, 1);
    chk("t3_q0", q0, 0);
    chk("t3_volta0", volta0, 1);
    chk("t3_voltas0", voltas0, 1);
    chk("t3_q1_sat", q1, 99);
    cyc(0, 0, 0, 0, 1);
    chk("t3_volta0_one_cycle", volta0, 0);

    // Down from zero wraps to M-1, then 99 more steps back to 0
    cyc(0, 0, 0, 1, 0);
    chk("t4_q99", q0, 99);
    chk("t4_voltas0", voltas0, 2);
    for (int k = 0; k < 99; k++) cyc(0, 0, 0, 1, 0);
    chk("t4_q0", q0, 0);

    // Load priority and clamping
    cyc(1, 1, 7'd42, 1, 1);
    chk("t5_zera_wins", q0, 0);
    cyc(0, 1, 7'd42, 1, 1);
    chk("t5_load42", q0, 42);
    cyc(0, 1, 7'd120, 1, 1);
    chk("t5_clamp", q0, 99);
    cyc(0, 0, 0, 1, 1);

    // Saturating run then async reset mid-count
    cyc(1, 0, 0, 0, 1);
    for (int k = 0; k < 150; k++) cyc(0, 0, 0, 1, 1);
    chk("t6_q1_hold", q1, 99);
    chk("t6_voltas1", voltas1, 0);
    areset_mid();
    cyc(0, 0, 0, 1, 1);
    chk("t6_resume", q0, 1);

    // Fast wraps to overflow voltas
    for (int k = 0; k < 300; k++) begin
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
    end

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        areset_mid();
      end else begin
        cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
            N'($urandom_range(0, 127)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
